// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared types and constants for the 5-stage pipeline hazard/sequencing
// controller.
//   ctrl_state_t                  : controller FSM state (RUN, MEM_WAIT, ERROR)
//   PIPELINE_CTRL_MEM_TIMEOUT_DEF : default memory watchdog limit (cycles)
//   PERF_CNT_W                    : width of the optional performance counters
//   sat_inc()                     : saturating increment for the perf counters
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } ctrl_state_t;

   localparam int PIPELINE_CTRL_MEM_TIMEOUT_DEF = 15;
   localparam int PERF_CNT_W                    = 32;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
      return (&v) ? v : v + PERF_CNT_W'(1);
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_if
// Bundles the hazard inputs, the data-memory req/ready handshake and the
// pipeline-register stall/flush enables exchanged between the controller and
// the datapath.
//   master : the controller (drives dmem_req, stalls, flushes, error flag)
//   slave  : the datapath   (drives hazard info, mw_mem_access, dmem_ready)
//
// Handshake: dmem_req is held high for as long as the EX/MW instruction needs
// memory; the access completes in the cycle where dmem_req and dmem_ready are
// both high. A cycle with dmem_req high and dmem_ready low is a wait cycle and
// the whole pipeline is held. dmem_ready is ignored while dmem_req is low,
// except after an (illegal) drop of mw_mem_access mid-wait, where the
// controller keeps holding the pipeline until dmem_ready arrives.
// -----------------------------------------------------------------------------
interface pipeline_ctrl_if;

   logic [4:0] id_rs1_addr;
   logic [4:0] id_rs2_addr;
   logic [4:0] ex_rd_addr;
   logic       ex_is_load;
   logic       ex_branch_taken;
   logic       mw_mem_access;
   logic       dmem_ready;
   logic       dmem_req;
   logic       stall_if;
   logic       stall_id;
   logic       stall_ex;
   logic       stall_mw;
   logic       flush_id;
   logic       flush_ex;
   logic       mem_timeout_err;

   modport master (
      input  id_rs1_addr, id_rs2_addr, ex_rd_addr, ex_is_load, ex_branch_taken,
             mw_mem_access, dmem_ready,
      output dmem_req, stall_if, stall_id, stall_ex, stall_mw, flush_id, flush_ex,
             mem_timeout_err
   );

   modport slave (
      output id_rs1_addr, id_rs2_addr, ex_rd_addr, ex_is_load, ex_branch_taken,
             mw_mem_access, dmem_ready,
      input  dmem_req, stall_if, stall_id, stall_ex, stall_mw, flush_id, flush_ex,
             mem_timeout_err
   );

endinterface

// File: rtl/pipeline_ctrl_perf.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_perf
// Three saturating 32-bit event counters for the pipeline controller.
//   clk, resetn          : clock, async active-low reset (counters clear to 0)
//   any_stall            : some stall output is set this cycle
//   flush_id             : IF/ID bubble this cycle
//   mem_stall            : data-memory wait cycle
//   perf_stall_cycles    : count of any_stall cycles
//   perf_flush_events    : count of flush_id cycles
//   perf_mem_wait_cycles : count of mem_stall cycles
// -----------------------------------------------------------------------------
module pipeline_ctrl_perf
   import pipeline_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  any_stall,
   input  logic                  flush_id,
   input  logic                  mem_stall,
   output logic [PERF_CNT_W-1:0] perf_stall_cycles,
   output logic [PERF_CNT_W-1:0] perf_flush_events,
   output logic [PERF_CNT_W-1:0] perf_mem_wait_cycles
);

   logic [PERF_CNT_W-1:0] stall_cnt_q;
   logic [PERF_CNT_W-1:0] flush_cnt_q;
   logic [PERF_CNT_W-1:0] mem_cnt_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         mem_cnt_q   <= '0;
      end else begin
         if (any_stall) stall_cnt_q <= sat_inc(stall_cnt_q);
         if (flush_id)  flush_cnt_q <= sat_inc(flush_cnt_q);
         if (mem_stall) mem_cnt_q   <= sat_inc(mem_cnt_q);
      end
   end

   assign perf_stall_cycles    = stall_cnt_q;
   assign perf_flush_events    = flush_cnt_q;
   assign perf_mem_wait_cycles = mem_cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Hazard and sequencing controller for the 5-stage RV32I pipeline. Produces
// hold (stall) and bubble (flush) enables for the PC, IF/ID, ID/EX and EX/MW
// registers from load-use hazards, taken branches and data-memory waits, and
// runs a watchdog on the data-memory handshake.
//   MEM_TIMEOUT : consecutive not-ready cycles that trip the watchdog (2..255)
//   clk, resetn : clock, async active-low reset (all outputs forced to 0)
//   pc          : pipeline_ctrl_if.master (hazard inputs, dmem handshake,
//                 stall/flush enables, sticky mem_timeout_err)
//   dbg_state   : current FSM state, for observation only
// Optional build macro PIPELINE_CTRL_PERF_EN adds perf_stall_cycles,
// perf_flush_events and perf_mem_wait_cycles (32-bit saturating counters).
//
// Priority, highest first: memory wait / ERROR (hold everything), taken
// branch (two bubbles), load-use (hold PC and IF/ID, one bubble into ID/EX).
// -----------------------------------------------------------------------------
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = PIPELINE_CTRL_MEM_TIMEOUT_DEF
) (
   input  logic                  clk,
   input  logic                  resetn,
   pipeline_ctrl_if.master       pc,
   output ctrl_state_t           dbg_state
`ifdef PIPELINE_CTRL_PERF_EN
   ,
   output logic [PERF_CNT_W-1:0] perf_stall_cycles,
   output logic [PERF_CNT_W-1:0] perf_flush_events,
   output logic [PERF_CNT_W-1:0] perf_mem_wait_cycles
`endif
);

   localparam int               CNT_W     = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

   ctrl_state_t      state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

   logic dmem_req_c;
   logic mem_stall_c;
   logic err_c;
   logic hazard;
   logic hold_all;
   logic branch_flush;
   logic load_use;

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Next state and memory-side outputs
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      dmem_req_c  = 1'b0;
      mem_stall_c = 1'b0;
      err_c       = 1'b0;
      case (state_q)
         RUN: begin
            dmem_req_c  = pc.mw_mem_access;
            mem_stall_c = pc.mw_mem_access & ~pc.dmem_ready;
            if (pc.mw_mem_access && !pc.dmem_ready) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = CNT_W'(1);
            end
         end
         MEM_WAIT: begin
            dmem_req_c  = pc.mw_mem_access;
            // Keep holding even if mw_mem_access dropped: the access is
            // still outstanding until memory answers.
            mem_stall_c = ~pc.dmem_ready;
            if (pc.dmem_ready) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == CNT_LIMIT) begin
               state_d = ERROR;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         ERROR: begin
            err_c = 1'b1;
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   // Pipeline-side decisions. Branch/load-use inputs are frozen while the
   // pipeline is held, so they are simply ignored until it moves again.
   assign hazard = pc.ex_is_load && (pc.ex_rd_addr != 5'd0) &&
                   ((pc.ex_rd_addr == pc.id_rs1_addr) || (pc.ex_rd_addr == pc.id_rs2_addr));

   assign hold_all     = mem_stall_c | err_c;
   assign branch_flush = ~hold_all & pc.ex_branch_taken;
   // A taken branch makes the ID instruction wrong-path, so it overrides load-use.
   assign load_use     = ~hold_all & ~pc.ex_branch_taken & hazard;

   // Every output is forced low while reset is asserted.
   assign pc.dmem_req        = resetn & dmem_req_c;
   assign pc.stall_if        = resetn & (hold_all | load_use);
   assign pc.stall_id        = resetn & (hold_all | load_use);
   assign pc.stall_ex        = resetn & hold_all;
   assign pc.stall_mw        = resetn & hold_all;
   assign pc.flush_id        = resetn & branch_flush;
   assign pc.flush_ex        = resetn & (branch_flush | load_use);
   assign pc.mem_timeout_err = resetn & err_c;

   assign dbg_state = state_q;

`ifdef PIPELINE_CTRL_PERF_EN
   pipeline_ctrl_perf u_perf (
      .clk                  (clk),
      .resetn               (resetn),
      .any_stall            (pc.stall_if | pc.stall_id | pc.stall_ex | pc.stall_mw),
      .flush_id             (pc.flush_id),
      .mem_stall            (resetn & mem_stall_c),
      .perf_stall_cycles    (perf_stall_cycles),
      .perf_flush_events    (perf_flush_events),
      .perf_mem_wait_cycles (perf_mem_wait_cycles)
   );
`else
   // Counters and their ports are not built.
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed bench for pipeline_ctrl with MEM_TIMEOUT = 4. Output vector order:
// {dmem_req, stall_if, stall_id, stall_ex, stall_mw, flush_id, flush_ex,
//  mem_timeout_err}. Inputs change 1 ns after the rising edge and outputs are
// checked 1 ns later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;
   import pipeline_ctrl_pkg::*;

   localparam int TIMEOUT = 4;

   localparam logic [7:0] O_NONE  = 8'b0000_0000;
   localparam logic [7:0] O_LU    = 8'b0110_0010;
   localparam logic [7:0] O_BR    = 8'b0000_0110;
   localparam logic [7:0] O_REQ   = 8'b1000_0000;
   localparam logic [7:0] O_WAIT  = 8'b1111_1000;
   localparam logic [7:0] O_DROP  = 8'b0111_1000;
   localparam logic [7:0] O_ERR   = 8'b0111_1001;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   pipeline_ctrl_if pc_if ();
   ctrl_state_t     dbg_state;
   logic [7:0]      outs;

`ifdef PIPELINE_CTRL_PERF_EN
   logic [PERF_CNT_W-1:0] perf_stall_cycles;
   logic [PERF_CNT_W-1:0] perf_flush_events;
   logic [PERF_CNT_W-1:0] perf_mem_wait_cycles;
`endif

   pipeline_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .pc        (pc_if),
      .dbg_state (dbg_state)
`ifdef PIPELINE_CTRL_PERF_EN
      ,
      .perf_stall_cycles    (perf_stall_cycles),
      .perf_flush_events    (perf_flush_events),
      .perf_mem_wait_cycles (perf_mem_wait_cycles)
`endif
   );

   assign outs = {pc_if.dmem_req, pc_if.stall_if, pc_if.stall_id, pc_if.stall_ex,
                  pc_if.stall_mw, pc_if.flush_id, pc_if.flush_ex, pc_if.mem_timeout_err};

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_hz(input logic ld, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic br);
      pc_if.ex_is_load      = ld;
      pc_if.ex_rd_addr      = rd;
      pc_if.id_rs1_addr     = rs1;
      pc_if.id_rs2_addr     = rs2;
      pc_if.ex_branch_taken = br;
   endtask

   task automatic set_mem(input logic acc, input logic rdy);
      pc_if.mw_mem_access = acc;
      pc_if.dmem_ready    = rdy;
   endtask

   // Watchdog: the sequence is finite, this only guards against a hang.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      resetn = 1'b0;
      set_hz(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      set_mem(1'b1, 1'b0);
      #2;
      chk("rst_outs_gated", 32'(outs), 32'(O_NONE));
      chk("rst_state", 32'(dbg_state), 32'(RUN));
      set_mem(1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;

      // Idle
      tick();
      #1 chk("idle", 32'(outs), 32'(O_NONE));

      // Load-use on rs1, then the load moves on
      tick(); set_hz(1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
      #1 chk("lu_rs1", 32'(outs), 32'(O_LU));
      tick(); set_hz(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      #1 chk("lu_one_bubble", 32'(outs), 32'(O_NONE));

      // Load-use on rs2
      tick(); set_hz(1'b1, 5'd7, 5'd1, 5'd7, 1'b0);
      #1 chk("lu_rs2", 32'(outs), 32'(O_LU));

      // rd = x0 never hazards
      tick(); set_hz(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
      #1 chk("lu_rd_x0", 32'(outs), 32'(O_NONE));

      // Matching registers but not a load
      tick(); set_hz(1'b0, 5'd5, 5'd5, 5'd5, 1'b0);
      #1 chk("no_load", 32'(outs), 32'(O_NONE));

      // Branch with load-use in the same cycle: branch wins
      tick(); set_hz(1'b1, 5'd5, 5'd5, 5'd0, 1'b1);
      #1 chk("br_over_lu", 32'(outs), 32'(O_BR));
      tick(); set_hz(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      #1 chk("br_after", 32'(outs), 32'(O_NONE));

      // Zero-wait access
      tick(); set_mem(1'b1, 1'b1);
      #1 chk("zw_req", 32'(outs), 32'(O_REQ));
      tick(); set_mem(1'b0, 1'b0);
      #1 chk("zw_state", 32'(dbg_state), 32'(RUN));
      chk("zw_after", 32'(outs), 32'(O_NONE));

      // 3-wait access; branch and hazard present but suppressed
      tick(); set_mem(1'b1, 1'b0); set_hz(1'b1, 5'd5, 5'd5, 5'd0, 1'b1);
      #1 chk("mw_c1", 32'(outs), 32'(O_WAIT));
      tick();
      #1 chk("mw_c2_state", 32'(dbg_state), 32'(MEM_WAIT));
      chk("mw_c2", 32'(outs), 32'(O_WAIT));
      tick();
      #1 chk("mw_c3", 32'(outs), 32'(O_WAIT));
      tick(); set_mem(1'b1, 1'b1); set_hz(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      #1 chk("mw_c4_done", 32'(outs), 32'(O_REQ));
      tick(); set_mem(1'b0, 1'b0);
      #1 chk("mw_back_run", 32'(dbg_state), 32'(RUN));
      chk("mw_after", 32'(outs), 32'(O_NONE));

      // Ready on the last cycle before the limit: no error
      for (int i = 0; i < 3; i++) begin
         tick(); set_mem(1'b1, 1'b0);
         #1 chk("lim_wait", 32'(outs), 32'(O_WAIT));
      end
      tick(); set_mem(1'b1, 1'b1);
      #1 chk("lim_ready", 32'(outs), 32'(O_REQ));
      tick(); set_mem(1'b0, 1'b0);
      #1 chk("lim_state", 32'(dbg_state), 32'(RUN));
      chk("lim_no_err", 32'(outs), 32'(O_NONE));

      // mw_mem_access dropped mid-wait: stall held until ready
      tick(); set_mem(1'b1, 1'b0);
      #1 chk("drop_c1", 32'(outs), 32'(O_WAIT));
      tick(); set_mem(1'b0, 1'b0);
      #1 chk("drop_hold", 32'(outs), 32'(O_DROP));
      tick(); set_mem(1'b0, 1'b1);
      #1 chk("drop_ready", 32'(outs), 32'(O_NONE));
      tick(); set_mem(1'b0, 1'b0);
      #1 chk("drop_state", 32'(dbg_state), 32'(RUN));

      // Reset asserted in MEM_WAIT
      tick(); set_mem(1'b1, 1'b0);
      #1 chk("rw_c1", 32'(outs), 32'(O_WAIT));
      tick();
      #1 chk("rw_state", 32'(dbg_state), 32'(MEM_WAIT));
      resetn = 1'b0;
      #1 chk("rw_outs_zero", 32'(outs), 32'(O_NONE));
      chk("rw_state_run", 32'(dbg_state), 32'(RUN));
      resetn = 1'b1;
      #1 chk("rw_reenter", 32'(outs), 32'(O_WAIT));
      set_mem(1'b0, 1'b0);

      // Watchdog timeout
      tick(); set_mem(1'b1, 1'b0);
      #1 chk("to_c1", 32'(outs), 32'(O_WAIT));
      for (int i = 0; i < 3; i++) begin
         tick();
         #1 chk("to_wait", 32'(outs), 32'(O_WAIT));
      end
      tick();
      #1 chk("to_state", 32'(dbg_state), 32'(ERROR));
      chk("to_err", 32'(outs), 32'(O_ERR));
      set_mem(1'b0, 1'b1); set_hz(1'b1, 5'd5, 5'd5, 5'd0, 1'b1);
      #1 chk("to_sticky_inputs", 32'(outs), 32'(O_ERR));
      tick();
      #1 chk("to_sticky_1", 32'(outs), 32'(O_ERR));
      tick();
      #1 chk("to_sticky_2", 32'(outs), 32'(O_ERR));
      resetn = 1'b0;
      #1 chk("to_rst_outs", 32'(outs), 32'(O_NONE));
      set_mem(1'b0, 1'b0); set_hz(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      resetn = 1'b1;
      #1 chk("to_rst_state", 32'(dbg_state), 32'(RUN));
      chk("to_rst_clear", 32'(outs), 32'(O_NONE));

`ifdef PIPELINE_CTRL_PERF_EN
      // Counters were cleared by the reset pulse above
      for (int i = 0; i < 3; i++) begin
         tick(); set_mem(1'b1, 1'b0);
      end
      tick(); set_mem(1'b1, 1'b1);
      tick(); set_mem(1'b0, 1'b0);
      #1 chk("perf_mem_wait", perf_mem_wait_cycles, 32'd3);
      chk("perf_stall", perf_stall_cycles, 32'd3);
      chk("perf_flush0", perf_flush_events, 32'd0);
      set_hz(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
      tick(); set_hz(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      #1 chk("perf_flush1", perf_flush_events, 32'd1);
      force dut.u_perf.flush_cnt_q = 32'hFFFF_FFFF;
      #1 release dut.u_perf.flush_cnt_q;
      set_hz(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
      tick(); set_hz(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      #1 chk("perf_saturate", perf_flush_events, 32'hFFFF_FFFF);
`endif

      // ---------------- final report ----------------
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the 5-stage RV32I pipeline. Each cycle it drives hold (stall) and bubble (flush) enables for the IF/ID, ID/EX and EX/MW pipeline registers, covering load-use hazards, taken-branch redirects and multi-cycle data-memory accesses. Data-memory accesses use a req/ready handshake with a watchdog timeout. It sits beside the datapath and sequences the pipeline registers; it owns no datapath state.

## Interface
- `MEM_TIMEOUT`, default 15: consecutive not-ready cycles that trigger the memory timeout error. Legal range is 2..255.

- `clk` in 1: rising-edge clock.
- `resetn` in 1: asynchronous, active-low reset.
- `id_rs1_addr` in 5: rs1 of the instruction in ID.
- `id_rs2_addr` in 5: rs2 of the instruction in ID.
- `ex_rd_addr` in 5: rd of the instruction in EX.
- `ex_is_load` in 1: the instruction in EX is a load.
- `ex_branch_taken` in 1: a branch or jump resolved taken in EX.
- `mw_mem_access` in 1: the instruction in EX/MW performs a load or store.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `dmem_req` out 1: data memory request.
- `stall_if` out 1: hold the PC.
- `stall_id` out 1: hold IF/ID.
- `stall_ex` out 1: hold ID/EX.
- `stall_mw` out 1: hold EX/MW.
- `flush_id` out 1: load a bubble into IF/ID.
- `flush_ex` out 1: load a bubble into ID/EX.
- `mem_timeout_err` out 1: sticky error flag.

## Operation
- FSM states: RUN, MEM_WAIT, ERROR. Reset state is RUN. Wait counter `wait_cnt` is `$clog2(MEM_TIMEOUT+1)` bits.
- **Memory stall (highest priority).**
  - `dmem_req` = `mw_mem_access` in RUN and MEM_WAIT; it is 0 in ERROR.
  - `mem_stall` = `dmem_req & ~dmem_ready`.
  - While `mem_stall` is set: all four stall outputs = 1 and both flushes = 0. Flush and load-use decisions are suppressed and are re-evaluated once the pipeline moves, because their inputs are held.
- **RUN transitions.**
  - `mw_mem_access & ~dmem_ready` → MEM_WAIT, `wait_cnt` ← 1.
  - `dmem_ready` in the same cycle as the access: zero-wait, stay in RUN.
- **MEM_WAIT transitions.**
  - `dmem_ready` → RUN, `wait_cnt` ← 0.
  - Else if `wait_cnt == MEM_TIMEOUT-1` → ERROR.
  - Else `wait_cnt` increments.
  - `dmem_ready` wins over the timeout in the same cycle.
  - `mw_mem_access` dropping while in MEM_WAIT is illegal; the controller still holds the stall until `dmem_ready`.
- **ERROR.**
  - All stalls = 1, flushes = 0, `dmem_req` = 0, `mem_timeout_err` = 1.
  - Exit only through reset.
- **Branch flush (when no memory stall).**
  - `ex_branch_taken` sets `flush_id` = `flush_ex` = 1 for that cycle, with no stalls.
  - This overrides a load-use hazard in the same cycle, since the ID instruction is wrong-path.
- **Load-use (when no memory stall or branch).**
  - Hazard = `ex_is_load & ex_rd_addr != 0 & (ex_rd_addr == id_rs1_addr | ex_rd_addr == id_rs2_addr)`.
  - On a hazard: `stall_if` = `stall_id` = 1 and `flush_ex` = 1 (one bubble).
  - The hazard self-clears the next cycle because the load moves on.
- All stall and flush outputs are combinational from the state plus current inputs.

## Timing
- Reset value of every output is 0:
  - While `resetn` is low, outputs are gated to 0.
  - State = RUN, `wait_cnt` = 0, `mem_timeout_err` = 0.
- Zero-wait access: no stall cycles.
- N-wait access (`dmem_ready` arriving N cycles after the request): exactly N stall cycles.
- Timeout: ERROR is entered at the edge closing the `MEM_TIMEOUT`-th consecutive not-ready cycle. `mem_timeout_err` rises the next cycle.
- Load-use: exactly 1 bubble. Branch: exactly 2 bubbles.
- Reset asserted mid-MEM_WAIT: immediate return to RUN and `dmem_req` drops asynchronously.

## Configuration
- Macro: `PIPELINE_CTRL_PERF_EN`.
- Defined: adds three 32-bit saturating counter outputs, all reset to 0:
  - `perf_stall_cycles`: cycles with any stall output set.
  - `perf_flush_events`: cycles with `flush_id` set.
  - `perf_mem_wait_cycles`: cycles with `mem_stall` set.
- Undefined: these ports and their logic are absent. Control behaviour is identical in both builds.

## Structure
- `pipeline_ctrl_pkg`:
  - `ctrl_state_t` enum {RUN, MEM_WAIT, ERROR}.
  - `PIPELINE_CTRL_MEM_TIMEOUT_DEF` = 15.
  - `PERF_CNT_W` = 32.
- Sub-module `pipeline_ctrl_perf`: the three saturating counters, instantiated only under `PIPELINE_CTRL_PERF_EN`.

## Test plan
- **Load-use:** `ex_is_load`=1, `ex_rd_addr`=5, `id_rs1_addr`=5 → for one cycle `stall_if`=`stall_id`=`flush_ex`=1; with `ex_rd_addr`=0 → no stall.
- **Branch + load-use same cycle:** `ex_branch_taken`=1 with the hazard present → `flush_id`=`flush_ex`=1, all stalls 0.
- **Memory wait:** `mw_mem_access`=1, `dmem_ready` low 3 cycles then high → `dmem_req`=1 for 4 cycles, all stalls high exactly 3 cycles, then RUN.
- **Timeout:** `MEM_TIMEOUT`=4, `dmem_ready` held 0 → ERROR after 4 cycles; `dmem_req`=0, `mem_timeout_err`=1 and stays 1 until `resetn` pulses.
- **Ready-at-limit and reset mid-wait:** `dmem_ready` on the 4th not-ready-limit cycle → RUN, no error. Reset asserted in MEM_WAIT → all outputs 0 immediately.
- **Perf build (`PIPELINE_CTRL_PERF_EN`):** the scenarios above yield expected counts, e.g. `perf_mem_wait_cycles`=3 after the memory-wait case; a forced counter at 0xFFFFFFFF holds its value.
